alu_exec: RTL

//  Execute-stage ALU that consumes the {alu_a, alu_b, alu_op} triple produced by execute control.
//  Add/sub/compare/logic complete in one cycle; shifts run on a 1-bit/cycle serial shifter.
//  The result is held in an output register under a valid/ready handshake toward writeback/branch logic.

---
 rtl/alu_exec_if.sv | 26 ++
 rtl/alu_exec.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// Handshake bundle between execute control, the execute ALU and writeback/branch logic.
// The master side issues operand triples and consumes results; the slave side is the ALU.
interface alu_exec_if #(
  parameter int word_width   = 32,
  parameter int alu_op_width = 4
) ();
  logic                    in_valid;
  logic                    in_ready;
  logic [word_width-1:0]   alu_a;
  logic [word_width-1:0]   alu_b;
  logic [alu_op_width-1:0] alu_op;
  logic                    out_valid;
  logic                    out_ready;
  logic [word_width-1:0]   result;
  logic                    zero;

  modport master (
    output in_valid, alu_a, alu_b, alu_op, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_a, alu_b, alu_op, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle add/sub/compare/logic, 1-bit-per-cycle serial shifter,
// result held in an output register under a valid/ready handshake.
module alu_exec #(
  parameter int word_width   = 32,
  parameter int alu_op_width = 4,
  parameter int shamt_width  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  alu_exec_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shkind_t;

  state_t                  state;
  logic [shamt_width-1:0]  cnt;
  logic                    out_valid_r;
  logic [word_width-1:0]   result_r;
  logic                    zero_r;

  logic [word_width-1:0]   sh_val;
  shkind_t                 sh_kind;

  logic [2:0]              op_f3;
  logic                    op_alt;
  logic [shamt_width-1:0]  shamt;
  logic                    is_shift;
  logic                    in_ready_c;
  logic                    accept;
  logic [word_width-1:0]   comb_res;
  logic [word_width-1:0]   next_sh;

  // Single-cycle operations; a shift reaching here has shamt 0 and passes alu_a through.
  function automatic logic [word_width-1:0] alu_comb(
    input logic [word_width-1:0] a,
    input logic [word_width-1:0] b,
    input logic [2:0]            f3,
    input logic                  alt
  );
    logic signed [word_width-1:0] sa;
    logic signed [word_width-1:0] sb;
    logic [word_width-1:0]        r;
    sa = signed'(a);
    sb = signed'(b);
    case (f3)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b010:  r = {{(word_width-1){1'b0}}, (sa < sb)};
      3'b011:  r = {{(word_width-1){1'b0}}, (a < b)};
      3'b100:  r = a ^ b;
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic [word_width-1:0] shift_step(
    input logic [word_width-1:0] v,
    input shkind_t               kind
  );
    logic [word_width-1:0] r;
    case (kind)
      SH_LL:   r = {v[word_width-2:0], 1'b0};
      SH_RA:   r = {v[word_width-1], v[word_width-1:1]};
      default: r = {1'b0, v[word_width-1:1]};
    endcase
    return r;
  endfunction

  assign op_f3      = bus.alu_op[alu_op_width-1 -: 3];
  assign op_alt     = bus.alu_op[0];
  assign shamt      = bus.alu_b[shamt_width-1:0];
  assign is_shift   = (op_f3 == 3'b001) || (op_f3 == 3'b101);
  assign in_ready_c = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign accept     = bus.in_valid && in_ready_c && !flush;

  always_comb begin
    comb_res = alu_comb(bus.alu_a, bus.alu_b, op_f3, op_alt);
    next_sh  = shift_step(sh_val, sh_kind);
  end

  // Control and result register: IDLE/DONE accept, SHIFT countdown, flush and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      zero_r      <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              state       <= SHIFT;
              cnt         <= shamt;
              out_valid_r <= 1'b0;
            end else begin
              state       <= DONE;
              result_r    <= comb_res;
              zero_r      <= (comb_res == '0);
              out_valid_r <= 1'b1;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == shamt_width'(1)) begin
            state       <= DONE;
            result_r    <= next_sh;
            zero_r      <= (next_sh == '0);
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Shifter datapath: loaded on accept, advanced one bit per SHIFT cycle; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_val  <= bus.alu_a;
      sh_kind <= (op_f3 == 3'b001) ? SH_LL : (op_alt ? SH_RA : SH_RL);
    end else if (state == SHIFT) begin
      sh_val  <= next_sh;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;

endmodule
